// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder.
// State encoding and the processor-facing widths.
package mem_responder_pkg;

   localparam int MEM_ADDR_W = 6;
   localparam int MEM_DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RD_DONE = 2'd2,
      ST_WR_DONE = 2'd3
   } mem_state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word store with async clear, one sync write port
// and an enable-gated registered read port.
module mem_responder_mem_array
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Holds its value between enabled reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: strobe handshake FSM with
// configurable read wait states in front of the array.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = MEM_DATA_W,
   parameter int RD_WAIT = 2
) (
   input  logic              clk,
   input  logic              proc_rst,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data_in,
   input  logic              mem_write,
   input  logic              mem_read,
   output logic [DATA_W-1:0] mem_data_out,
   output logic              mem_ready,
   output logic              mem_busy
);

   localparam logic [3:0] CNT_INIT = 4'(RD_WAIT);
   localparam bit NO_WAIT = (RD_WAIT == 0);

   mem_state_t        state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addr_q;

   logic              idle;
   logic              wr_acc;
   logic              rd_acc;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;

   assign idle   = (state == ST_IDLE);
   assign wr_acc = idle && mem_write;
   assign rd_acc = idle && mem_read && !mem_write;

   // Array read fires on the edge that enters RD_DONE.
   assign rd_en   = (rd_acc && NO_WAIT) ||
                    (state == ST_RD_WAIT && cnt == 4'd1);
   assign rd_addr = idle ? mem_addr : addr_q;

   assign mem_ready = (state == ST_RD_DONE) ||
                      (state == ST_WR_DONE);
   assign mem_busy  = !idle;

   always_ff @(posedge clk or negedge proc_rst) begin
      if (!proc_rst) begin
         state  <= ST_IDLE;
         cnt    <= 4'd0;
         addr_q <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (mem_write) begin
                  state <= ST_WR_DONE;
               end else if (mem_read) begin
                  addr_q <= mem_addr;
                  cnt    <= CNT_INIT;
                  state  <= NO_WAIT ? ST_RD_DONE : ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               if (cnt == 4'd1) begin
                  cnt   <= 4'd0;
                  state <= ST_RD_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RD_DONE,
            ST_WR_DONE: state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

   mem_responder_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem_array (
      .clk     (clk),
      .rst_n   (proc_rst),
      .we      (wr_acc),
      .wr_addr (mem_addr),
      .wr_data (mem_data_in),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (mem_data_out)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: one 2-wait and one
// 0-wait instance checked against an array/latency model.
module tb_mem_responder;

   localparam int RW0 = 2;
   localparam int RW1 = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [2];
   logic [5:0]  addr  [2];
   logic [15:0] din   [2];
   logic        wrq   [2];
   logic        rdq   [2];

   logic [15:0] dout0, dout1;
   logic        rdy0, rdy1, bsy0, bsy1;

   int checks   = 0;
   int failures = 0;

   logic [15:0] model    [2][64];
   logic [15:0] last_out [2];

   mem_responder #(.ADDR_W(6), .DATA_W(16), .RD_WAIT(RW0)) dut0 (
      .clk          (clk),
      .proc_rst     (rst[0]),
      .mem_addr     (addr[0]),
      .mem_data_in  (din[0]),
      .mem_write    (wrq[0]),
      .mem_read     (rdq[0]),
      .mem_data_out (dout0),
      .mem_ready    (rdy0),
      .mem_busy     (bsy0)
   );

   mem_responder #(.ADDR_W(6), .DATA_W(16), .RD_WAIT(RW1)) dut1 (
      .clk          (clk),
      .proc_rst     (rst[1]),
      .mem_addr     (addr[1]),
      .mem_data_in  (din[1]),
      .mem_write    (wrq[1]),
      .mem_read     (rdq[1]),
      .mem_data_out (dout1),
      .mem_ready    (rdy1),
      .mem_busy     (bsy1)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] get_out(input int k);
      return (k == 0) ? dout0 : dout1;
   endfunction

   function automatic logic get_rdy(input int k);
      return (k == 0) ? rdy0 : rdy1;
   endfunction

   function automatic logic get_bsy(input int k);
      return (k == 0) ? bsy0 : bsy1;
   endfunction

   function automatic int rdw(input int k);
      return (k == 0) ? RW0 : RW1;
   endfunction

   task automatic clear_model(input int k);
      for (int i = 0; i < 64; i++) model[k][i] = 16'h0;
      last_out[k] = 16'h0;
   endtask

   task automatic do_access(input int k, input bit rd, input bit wr,
                            input logic [5:0] a, input logic [15:0] d);
      int          edges;
      int          exp_lat;
      bit          seen;
      logic [15:0] exp_out;
      @(posedge clk); #1;
      check("idle_ready", 32'(get_rdy(k)), 32'd0);
      check("idle_busy", 32'(get_bsy(k)), 32'd0);
      check("idle_out", 32'(get_out(k)), 32'(last_out[k]));
      @(negedge clk);
      addr[k] = a;
      din[k]  = d;
      rdq[k]  = rd;
      wrq[k]  = wr;
      @(posedge clk); #1;
      rdq[k]  = 1'b0;
      wrq[k]  = 1'b0;
      addr[k] = ~a;
      din[k]  = 16'($urandom);
      if (wr) begin
         model[k][a] = d;
         exp_lat = 1;
         exp_out = last_out[k];
      end else begin
         exp_lat = rdw(k) + 1;
         exp_out = model[k][a];
      end
      edges = 1;
      seen  = 1'b0;
      while (!seen && edges <= 40) begin
         check("busy", 32'(get_bsy(k)), 32'd1);
         if (get_rdy(k)) begin
            seen = 1'b1;
         end else begin
            check("hold_out", 32'(get_out(k)), 32'(last_out[k]));
            @(posedge clk); #1;
            edges++;
         end
      end
      if (!seen) begin
         check("ready_timeout", 32'd0, 32'd1);
      end else begin
         check(wr ? "wr_latency" : "rd_latency", 32'(edges), 32'(exp_lat));
         check(wr ? "wr_out" : "rd_data", 32'(get_out(k)), 32'(exp_out));
      end
      last_out[k] = exp_out;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst[k]  = 1'b0;
         addr[k] = 6'h0;
         din[k]  = 16'h0;
         wrq[k]  = 1'b0;
         rdq[k]  = 1'b0;
         clear_model(k);
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_out0", 32'(dout0), 32'd0);
      check("rst_rdy0", 32'(rdy0), 32'd0);
      check("rst_bsy0", 32'(bsy0), 32'd0);
      check("rst_out1", 32'(dout1), 32'd0);
      check("rst_rdy1", 32'(rdy1), 32'd0);
      check("rst_bsy1", 32'(bsy1), 32'd0);
      @(negedge clk);
      rst[0] = 1'b1;
      rst[1] = 1'b1;

      do_access(0, 1'b1, 1'b0, 6'd5, 16'h0);
      do_access(0, 1'b0, 1'b1, 6'd63, 16'hBEEF);
      do_access(0, 1'b1, 1'b0, 6'd63, 16'h0);
      do_access(0, 1'b0, 1'b1, 6'd2, 16'h1234);
      do_access(0, 1'b0, 1'b1, 6'd3, 16'h5678);
      do_access(0, 1'b1, 1'b0, 6'd2, 16'h0);
      do_access(0, 1'b1, 1'b1, 6'd7, 16'h00AA);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("both_no_2nd_ready", 32'(rdy0), 32'd0);
      end
      do_access(0, 1'b1, 1'b0, 6'd7, 16'h0);

      @(negedge clk);
      rdq[0]  = 1'b1;
      addr[0] = 6'd63;
      @(posedge clk); #1;
      rdq[0] = 1'b0;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      #1;
      check("midrst_out", 32'(dout0), 32'd0);
      check("midrst_rdy", 32'(rdy0), 32'd0);
      check("midrst_bsy", 32'(bsy0), 32'd0);
      clear_model(0);
      @(negedge clk);
      @(negedge clk);
      rst[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("postrst_no_ready", 32'(rdy0), 32'd0);
      end
      do_access(0, 1'b1, 1'b0, 6'd63, 16'h0);
      do_access(0, 1'b1, 1'b0, 6'd2, 16'h0);

      do_access(1, 1'b0, 1'b1, 6'd1, 16'hA5A1);
      do_access(1, 1'b0, 1'b1, 6'd2, 16'h5A52);
      do_access(1, 1'b1, 1'b0, 6'd1, 16'h0);
      do_access(1, 1'b1, 1'b0, 6'd2, 16'h0);
      @(posedge clk); #1;
      check("b2b_gap", 32'(rdy1), 32'd0);

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 150; i++) begin
            int          op;
            logic [5:0]  a;
            logic [15:0] d;
            op = int'($urandom_range(0, 9));
            a  = 6'($urandom);
            d  = 16'($urandom);
            if (op < 4) do_access(k, 1'b1, 1'b0, a, d);
            else if (op < 8) do_access(k, 1'b0, 1'b1, a, d);
            else do_access(k, 1'b1, 1'b1, a, d);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
